regfile_dump: RTL and testbench

Sequential debug reader for the integer register file. On a start pulse it walks the register addresses through one register-file read port and returns each value as an index/data beat on a valid/ready stream. It accounts for the register file's one-cycle synchronous read latency and its read suppression when a write collides with a read address. It sits beside the datapath, sharing read port 2 and snooping the write port, and feeds a debug or trace consumer.

---
 rtl/regfile_dump.sv | 122 ++++++++++++
 tb/tb_regfile_dump.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump.sv
// Sequential debug reader: walks the integer register file through read port 2
// and streams each register as an index/data beat on a valid/ready interface.
module regfile_dump #(
  parameter int NREGS   = 32,
  parameter bit SKIP_X0 = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [31:0] rf_ra,
  input  logic [31:0] rf_dr,
  input  logic [31:0] rf_ra_other,
  input  logic        rf_we,
  input  logic [31:0] rf_wa,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_idx,
  output logic [31:0] out_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_e;

  localparam logic [4:0] FIRST_IDX = SKIP_X0 ? 5'd1 : 5'd0;
  localparam logic [4:0] LAST_IDX  = 5'(NREGS - 1);

  state_e      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic        out_valid_q, out_valid_d;
  logic [4:0]  out_idx_q, out_idx_d;
  logic [31:0] out_data_q, out_data_d;
  logic        done_q, done_d;
  logic        collision;

  // The register file suppresses its read whenever a write hits either read address.
  assign rf_ra     = {27'd0, idx_q};
  assign collision = rf_we && ((rf_wa == rf_ra) || (rf_wa == rf_ra_other));

  // Stream handshake: a beat transfers at a rising edge where out_valid && out_ready;
  // once raised, out_valid and the payload hold until that transfer (or abort/reset).
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = FIRST_IDX;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!collision) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        out_data_d  = rf_dr;
        out_idx_d   = idx_q;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort outranks a simultaneous handshake: the held beat is dropped.
    if (abort && (state_q != IDLE)) begin
      state_d     = IDLE;
      idx_d       = idx_q;
      out_valid_d = 1'b0;
      done_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= 5'd0;
      out_valid_q <= 1'b0;
      out_idx_q   <= 5'd0;
      out_data_q  <= 32'd0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: a register-file model with read suppression on
// write collisions feeds two instances (full walk and walk skipping x0).
module tb_regfile_dump;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start0, start1, abort, out_ready;
  logic        rf_we;
  logic [31:0] rf_wa, rf_wd, rf_ra_other;

  logic [31:0] ra0, ra1;
  logic [31:0] dr0, dr1;
  logic        busy0, busy1, done0, done1, ov0, ov1;
  logic [4:0]  oi0, oi1;
  logic [31:0] od0, od1;

  logic [31:0] mem [32];
  logic [31:0] golden [32];
  logic [36:0] exp_q [$];

  int n_pass  = 0;
  int n_total = 0;

  logic        which_sel;
  logic        s_busy, s_done, s_valid;
  logic [4:0]  s_idx;
  logic [31:0] s_data, s_ra;

  assign s_busy  = which_sel ? busy1 : busy0;
  assign s_done  = which_sel ? done1 : done0;
  assign s_valid = which_sel ? ov1   : ov0;
  assign s_idx   = which_sel ? oi1   : oi0;
  assign s_data  = which_sel ? od1   : od0;
  assign s_ra    = which_sel ? ra1   : ra0;

  regfile_dump #(.NREGS(32), .SKIP_X0(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort), .busy(busy0), .done(done0),
    .rf_ra(ra0), .rf_dr(dr0), .rf_ra_other(rf_ra_other), .rf_we(rf_we), .rf_wa(rf_wa),
    .out_valid(ov0), .out_ready(out_ready), .out_idx(oi0), .out_data(od0)
  );

  regfile_dump #(.NREGS(32), .SKIP_X0(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort), .busy(busy1), .done(done1),
    .rf_ra(ra1), .rf_dr(dr1), .rf_ra_other(rf_ra_other), .rf_we(rf_we), .rf_wa(rf_wa),
    .out_valid(ov1), .out_ready(out_ready), .out_idx(oi1), .out_data(od1)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- register file model ----------------
  wire coll0 = rf_we && ((rf_wa == ra0) || (rf_wa == rf_ra_other));
  wire coll1 = rf_we && ((rf_wa == ra1) || (rf_wa == rf_ra_other));

  always @(posedge clk) begin
    if (rf_we) mem[rf_wa[4:0]] <= rf_wd;
    if (!coll0) dr0 <= mem[ra0[4:0]];
    if (!coll1) dr1 <= mem[ra1[4:0]];
  end

  // ---------------- driver / check tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic fill_exp(input int first, input int last);
    exp_q.delete();
    for (int k = first; k <= last; k++) exp_q.push_back({5'(k), golden[k]});
  endtask

  task automatic run_dump(input bit which, input bit toggle_rdy, input int inj_idx,
                          input bit inj_other, input int abort_idx, input int extra_start,
                          output int done_edge, output int first_valid,
                          output int stalls, output int nbeats);
    int          cyc;
    int          coll_left;
    bit          aborted, prev_stall, hs, ab;
    logic [4:0]  p_idx;
    logic [31:0] p_data;
    logic [36:0] exp_beat;
    cyc = 0; coll_left = 0; aborted = 0; prev_stall = 0;
    p_idx = '0; p_data = '0;
    done_edge = -1; first_valid = -1; stalls = 0; nbeats = 0;
    which_sel = which;
    if (which) start1 = 1'b1; else start0 = 1'b1;
    tick();
    start0 = 1'b0; start1 = 1'b0;
    check("busy_after_start", s_busy, 1);
    while (cyc < 400 && done_edge < 0 && !aborted) begin
      if (first_valid < 0 && s_valid) first_valid = cyc;
      if (prev_stall) begin
        check("hold_valid", s_valid, 1);
        check("hold_idx", s_idx, p_idx);
        check("hold_data", s_data, p_data);
      end
      out_ready = toggle_rdy ? (cyc % 2 == 1) : 1'b1;
      if (cyc == extra_start) begin
        if (which) start1 = 1'b1; else start0 = 1'b1;
      end
      if (coll_left > 0) begin
        if (coll_left == 2) check("rf_ra_in_issue", s_ra, 32'(inj_idx));
        rf_we       = 1'b1;
        rf_wa       = inj_other ? 32'd20 : 32'(inj_idx);
        rf_ra_other = inj_other ? 32'd20 : 32'd31;
        rf_wd       = inj_other ? 32'hBEEF : 32'hDEAD;
        coll_left--;
      end else begin
        rf_we       = 1'b0;
        rf_ra_other = 32'd31;
      end
      ab = s_valid && (int'(s_idx) == abort_idx);
      abort = ab;
      if (ab) out_ready = 1'b1;
      hs = s_valid && out_ready && !ab;
      if (hs) begin
        exp_beat = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        check("beat", {s_idx, s_data}, exp_beat);
        nbeats++;
        if (int'(s_idx) == inj_idx - 1) coll_left = 2;
      end
      prev_stall = s_valid && !out_ready;
      if (prev_stall) stalls++;
      p_idx = s_idx; p_data = s_data;
      tick();
      cyc++;
      start0 = 1'b0; start1 = 1'b0;
      if (ab) begin
        aborted = 1;
        abort = 1'b0;
        check("abort_busy", s_busy, 0);
        check("abort_valid", s_valid, 0);
        check("abort_done", s_done, 0);
      end else if (s_done) begin
        done_edge = cyc;
        check("busy_at_done", s_busy, 0);
      end
    end
    rf_we = 1'b0;
    out_ready = 1'b1;
    if (!aborted) begin
      check("done_seen", done_edge >= 0, 1);
      tick();
      check("done_one_cycle", s_done, 0);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int de, fv, st, nb;
    rst_n = 1'b0; start0 = 0; start1 = 0; abort = 0; out_ready = 1;
    rf_we = 0; rf_wa = '0; rf_wd = '0; rf_ra_other = 32'd31;
    which_sel = 1'b0;
    for (int k = 0; k < 32; k++) golden[k] = 32'h1000 + 32'(k);
    repeat (3) tick();
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_valid", ov0, 0);
    check("rst_idx", oi0, 0);
    check("rst_data", od0, 0);
    check("rst_ra", ra0, 0);
    rst_n = 1'b1;
    tick();

    // Preload x[k] = 0x1000 + k through the write port while both readers idle.
    for (int k = 0; k < 32; k++) begin
      rf_we = 1'b1; rf_wa = 32'(k); rf_wd = 32'h1000 + 32'(k);
      tick();
    end
    rf_we = 1'b0;
    tick();

    // Full dump, no stalls.
    fill_exp(0, 31);
    run_dump(0, 0, -1, 0, -1, -1, de, fv, st, nb);
    check("full_first_valid", fv, 2);
    check("full_done_edge", de, 96);
    check("full_nbeats", nb, 32);
    check("full_exp_left", exp_q.size(), 0);

    // Backpressure: out_ready toggles, each beat stalls one cycle.
    fill_exp(0, 31);
    run_dump(0, 1, -1, 0, -1, -1, de, fv, st, nb);
    check("bp_stalls", st, 32);
    check("bp_done_edge", de, 96 + 32);
    check("bp_nbeats", nb, 32);

    // Collision on write address == rf_ra at idx 5, new value 0xDEAD.
    golden[5] = 32'hDEAD;
    fill_exp(0, 31);
    run_dump(0, 0, 5, 0, -1, -1, de, fv, st, nb);
    check("coll_ra_done_edge", de, 98);
    check("coll_ra_nbeats", nb, 32);

    // Collision via the other read port address while idx 5 is issued.
    golden[20] = 32'hBEEF;
    fill_exp(0, 31);
    run_dump(0, 0, 5, 1, -1, -1, de, fv, st, nb);
    check("coll_other_done_edge", de, 98);
    check("coll_other_nbeats", nb, 32);

    // Abort while the idx-10 beat is held with out_ready high.
    fill_exp(0, 9);
    run_dump(0, 0, -1, 0, 10, -1, de, fv, st, nb);
    check("abort_nbeats", nb, 10);
    check("abort_exp_left", exp_q.size(), 0);
    repeat (3) begin
      tick();
      check("abort_no_done", done0, 0);
    end
    fill_exp(0, 31);
    run_dump(0, 0, -1, 0, -1, -1, de, fv, st, nb);
    check("restart_done_edge", de, 96);

    // start and abort together in IDLE: start wins; then abort cancels.
    which_sel = 1'b0;
    start0 = 1'b1; abort = 1'b1;
    tick();
    start0 = 1'b0; abort = 1'b0;
    check("start_beats_abort", busy0, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_issue_busy", busy0, 0);
    check("abort_issue_valid", ov0, 0);
    tick();

    // Asynchronous reset while a beat is held.
    out_ready = 1'b0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int i = 0; i < 10 && !ov0; i++) tick();
    check("hold_reached", ov0, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", ov0, 0);
    check("arst_busy", busy0, 0);
    check("arst_done", done0, 0);
    check("arst_data", od0, 0);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    fill_exp(0, 31);
    run_dump(0, 0, -1, 0, -1, -1, de, fv, st, nb);
    check("post_rst_first_valid", fv, 2);
    check("post_rst_done_edge", de, 96);

    // SKIP_X0 instance with a stray start mid-dump.
    fill_exp(1, 31);
    run_dump(1, 0, -1, 0, -1, 10, de, fv, st, nb);
    check("skip_first_valid", fv, 2);
    check("skip_nbeats", nb, 31);
    check("skip_done_edge", de, 93);
    check("skip_exp_left", exp_q.size(), 0);
    check("skip_idle_after", busy1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
